// File: rtl/axi_wr_slave.sv
// axi_wr_slave: AXI write slave that turns each AW/W burst into SRAM word writes and returns one B response.
// Latency: SRAM write in the same cycle as the W handshake; B valid one cycle after the last W beat.
// Backpressure: one burst outstanding; AW is held off until B completes. Optional macro AXI_WR_B2B_EN lets AW be accepted in the B handshake cycle.
module axi_wr_slave #(
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [IDS_W-1:0]      i_awid,
  input  logic [ADDR_W-1:0]     i_awaddr,
  input  logic [3:0]            i_awlen,
  input  logic [2:0]            i_awsize,
  input  logic [1:0]            i_awburst,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wstrb,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [IDS_W-1:0]      o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic                  o_sram_cs,
  output logic [DATA_W/8-1:0]   o_sram_web,
  output logic [MEM_AW-1:0]     o_sram_a,
  output logic [DATA_W-1:0]     o_sram_di
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t              r_state;
  logic                r_awready;
  logic                r_wready;
  logic                r_bvalid;
  logic [IDS_W-1:0]    r_bid;
  logic [1:0]          r_bresp;
  logic [IDS_W-1:0]    r_id;
  logic [MEM_AW-1:0]   r_base;
  logic [3:0]          r_len;
  logic                r_fixed;
  logic                r_err;
  logic [3:0]          r_cnt;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_b_hs;
  logic                w_last_cnt;
  logic                w_beat_err;
  logic                w_aw_bad;
  logic [MEM_AW-1:0]   w_wr_addr;
  logic                w_unused_addr;

  // Only the word-address slice of awaddr reaches the SRAM; the rest is intentionally dropped.
  assign w_unused_addr = ^{i_awaddr[ADDR_W-1:MEM_AW+2], i_awaddr[1:0]};

`ifdef AXI_WR_B2B_EN
  // Accept the next AW in the same cycle the B response is taken.
  assign o_awready = r_awready | ((r_state == S_RESP) & i_bready);
`else
  assign o_awready = r_awready;
`endif

  assign o_wready   = r_wready;
  assign o_bvalid   = r_bvalid;
  assign o_bid      = r_bid;
  assign o_bresp    = r_bresp;

  assign w_aw_hs    = i_awvalid & o_awready;
  assign w_w_hs     = i_wvalid & r_wready;
  assign w_b_hs     = r_bvalid & i_bready;
  assign w_aw_bad   = i_awburst[1] | (i_awsize != 3'b010);
  // Beat counter decides the final beat; a wlast disagreeing with it poisons this beat and the rest.
  assign w_last_cnt = (r_cnt == r_len);
  assign w_beat_err = r_err | (i_wlast ^ w_last_cnt);
  assign w_wr_addr  = r_fixed ? r_base : r_base + MEM_AW'(r_cnt);

  // SRAM port is driven straight from the W handshake; errored beats are swallowed.
  assign o_sram_cs  = w_w_hs & ~w_beat_err;
  assign o_sram_web = o_sram_cs ? ~i_wstrb : {(DATA_W/8){1'b1}};
  assign o_sram_a   = w_w_hs ? w_wr_addr : '0;
  assign o_sram_di  = w_w_hs ? i_wdata : '0;

  // Burst FSM with registered handshake outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= 2'b00;
      r_id      <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_fixed   <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_aw_hs) begin
            r_id      <= i_awid;
            r_base    <= i_awaddr[MEM_AW+1:2];
            r_len     <= i_awlen;
            r_fixed   <= ~i_awburst[0];
            r_err     <= w_aw_bad;
            r_cnt     <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_state   <= S_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_w_hs) begin
            r_cnt <= r_cnt + 4'd1;
            r_err <= w_beat_err;
            if (w_last_cnt) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= w_beat_err ? 2'b10 : 2'b00;
              r_state  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (w_b_hs) begin
            r_bvalid <= 1'b0;
`ifdef AXI_WR_B2B_EN
            if (w_aw_hs) begin
              r_id     <= i_awid;
              r_base   <= i_awaddr[MEM_AW+1:2];
              r_len    <= i_awlen;
              r_fixed  <= ~i_awburst[0];
              r_err    <= w_aw_bad;
              r_cnt    <= '0;
              r_wready <= 1'b1;
              r_state  <= S_DATA;
            end else begin
              r_awready <= 1'b1;
              r_state   <= S_IDLE;
            end
`else
            r_awready <= 1'b1;
            r_state   <= S_IDLE;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_slave.sv
// tb_axi_wr_slave: directed bench for axi_wr_slave covering bursts, error paths, backpressure, reset and AW spacing.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled 1 time unit later.
// The expected AW spacing follows AXI_WR_B2B_EN when the bench is built with it.
module tb_axi_wr_slave;
  localparam int IDS_W  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MEM_AW = 14;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic [IDS_W-1:0]    i_awid;
  logic [ADDR_W-1:0]   i_awaddr;
  logic [3:0]          i_awlen;
  logic [2:0]          i_awsize;
  logic [1:0]          i_awburst;
  logic                i_awvalid;
  logic                o_awready;
  logic [DATA_W-1:0]   i_wdata;
  logic [3:0]          i_wstrb;
  logic                i_wlast;
  logic                i_wvalid;
  logic                o_wready;
  logic [IDS_W-1:0]    o_bid;
  logic [1:0]          o_bresp;
  logic                o_bvalid;
  logic                i_bready;
  logic                o_sram_cs;
  logic [3:0]          o_sram_web;
  logic [MEM_AW-1:0]   o_sram_a;
  logic [DATA_W-1:0]   o_sram_di;

  int checks = 0;
  int errors = 0;

  axi_wr_slave #(.IDS_W(IDS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .o_sram_cs(o_sram_cs), .o_sram_web(o_sram_web), .o_sram_a(o_sram_a), .o_sram_di(o_sram_di)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Present AW and hold it until accepted (bounded), then drop awvalid after the handshake edge.
  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst;
    i_awvalid = 1'b1;
    #1;
    for (int n = 0; n < 20 && o_awready !== 1'b1; n++) tick;
    chk($sformatf("aw_ready_id%0h", id), o_awready, 1);
    tick;
    i_awvalid = 1'b0;
  endtask

  // One W beat with the SRAM signals expected during its handshake cycle.
  task automatic send_beat(input string tag, input logic [31:0] data, input logic [3:0] strb,
                           input logic last, input logic exp_cs, input logic [13:0] exp_a);
    logic [3:0] exp_web;
    exp_web = exp_cs ? ~strb : 4'hF;
    i_wdata = data; i_wstrb = strb; i_wlast = last; i_wvalid = 1'b1;
    #1;
    chk({tag, "_wready"}, o_wready, 1);
    chk({tag, "_cs"}, o_sram_cs, exp_cs);
    chk({tag, "_web"}, o_sram_web, exp_web);
    if (exp_cs) begin
      chk({tag, "_a"}, o_sram_a, exp_a);
      chk({tag, "_di"}, o_sram_di, data);
    end
    tick;
    i_wvalid = 1'b0; i_wlast = 1'b0;
  endtask

  // Check the B response, take it, and check the return to IDLE.
  task automatic take_resp(input string tag, input logic [7:0] id, input logic [1:0] resp);
    #1;
    chk({tag, "_bvalid"}, o_bvalid, 1);
    chk({tag, "_bid"}, o_bid, id);
    chk({tag, "_bresp"}, o_bresp, resp);
    chk({tag, "_wready_resp"}, o_wready, 0);
    i_bready = 1'b1;
    tick;
    i_bready = 1'b0;
    #1;
    chk({tag, "_bvalid_off"}, o_bvalid, 0);
    chk({tag, "_awready_back"}, o_awready, 1);
  endtask

  initial begin : main
    int aw0, aw1, n_aw;
    logic w_pend;

    i_rst = 1'b1; i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = 3'b010; i_awburst = 2'b01;
    i_awvalid = 1'b0; i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
    #1;
    // Reset values
    chk("rst_awready", o_awready, 0);
    chk("rst_wready", o_wready, 0);
    chk("rst_bvalid", o_bvalid, 0);
    chk("rst_bid", o_bid, 0);
    chk("rst_bresp", o_bresp, 0);
    chk("rst_cs", o_sram_cs, 0);
    chk("rst_web", o_sram_web, 4'hF);
    chk("rst_a", o_sram_a, 0);
    chk("rst_di", o_sram_di, 0);
    tick; tick;
    i_rst = 1'b0;
    #1;
    chk("rel_awready_low", o_awready, 0);
    tick;
    chk("rel_awready_up", o_awready, 1);

    // wvalid in IDLE is ignored
    i_wvalid = 1'b1; i_wstrb = 4'hF; i_wdata = 32'h1111_2222;
    #1;
    chk("idle_wready", o_wready, 0);
    chk("idle_cs", o_sram_cs, 0);
    tick;
    i_wvalid = 1'b0;

    // Single beat
    send_aw(8'h12, 32'h0001_0010, 4'd0, 3'b010, 2'b01);
    send_beat("single", 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 14'h0004);
    take_resp("single", 8'h12, 2'b00);

    // INCR wrapping at the top of the word space
    send_aw(8'h21, 32'h0000_FFF8, 4'd3, 3'b010, 2'b01);
    send_beat("incr0", 32'hA0A0_0000, 4'b0101, 1'b0, 1'b1, 14'h3FFE);
    // Idle cycle inside DATA: no SRAM activity
    #1;
    chk("incr_gap_cs", o_sram_cs, 0);
    chk("incr_gap_web", o_sram_web, 4'hF);
    tick;
    send_beat("incr1", 32'hA0A0_0001, 4'b0101, 1'b0, 1'b1, 14'h3FFF);
    send_beat("incr2", 32'hA0A0_0002, 4'b0101, 1'b0, 1'b1, 14'h0000);
    send_beat("incr3", 32'hA0A0_0003, 4'b0101, 1'b1, 1'b1, 14'h0001);
    take_resp("incr", 8'h21, 2'b00);

    // FIXED burst
    send_aw(8'h33, 32'h0000_0080, 4'd2, 3'b010, 2'b00);
    send_beat("fix0", 32'h0000_00F0, 4'hF, 1'b0, 1'b1, 14'h0020);
    send_beat("fix1", 32'h0000_00F1, 4'hC, 1'b0, 1'b1, 14'h0020);
    send_beat("fix2", 32'h0000_00F2, 4'h3, 1'b1, 1'b1, 14'h0020);
    take_resp("fix", 8'h33, 2'b00);

    // Early wlast on beat 2 of 4
    send_aw(8'h44, 32'h0000_0200, 4'd3, 3'b010, 2'b01);
    send_beat("badl0", 32'hB0, 4'hF, 1'b0, 1'b1, 14'h0080);
    send_beat("badl1", 32'hB1, 4'hF, 1'b1, 1'b0, 14'h0081);
    send_beat("badl2", 32'hB2, 4'hF, 1'b0, 1'b0, 14'h0082);
    send_beat("badl3", 32'hB3, 4'hF, 1'b1, 1'b0, 14'h0083);
    take_resp("badl", 8'h44, 2'b10);

    // Unsupported burst type
    send_aw(8'h55, 32'h0000_0300, 4'd1, 3'b010, 2'b10);
    send_beat("badb0", 32'hC0, 4'hF, 1'b0, 1'b0, 14'h00C0);
    send_beat("badb1", 32'hC1, 4'hF, 1'b1, 1'b0, 14'h00C1);
    take_resp("badb", 8'h55, 2'b10);

    // Unsupported size
    send_aw(8'h56, 32'h0000_0300, 4'd0, 3'b011, 2'b01);
    send_beat("bads0", 32'hC2, 4'hF, 1'b1, 1'b0, 14'h00C0);
    take_resp("bads", 8'h56, 2'b10);

    // B backpressure
    send_aw(8'h77, 32'h0000_0040, 4'd0, 3'b010, 2'b01);
    send_beat("bp", 32'h7777_0000, 4'hF, 1'b1, 1'b1, 14'h0010);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_bvalid_c%0d", c), o_bvalid, 1);
      chk($sformatf("bp_bid_c%0d", c), o_bid, 8'h77);
      chk($sformatf("bp_bresp_c%0d", c), o_bresp, 2'b00);
      chk($sformatf("bp_awready_c%0d", c), o_awready, 0);
      tick;
    end
    take_resp("bp", 8'h77, 2'b00);

    // Reset in the middle of a burst
    send_aw(8'h88, 32'h0000_0400, 4'd3, 3'b010, 2'b01);
    send_beat("mrst0", 32'hD0, 4'hF, 1'b0, 1'b1, 14'h0100);
    i_wdata = 32'hD1; i_wstrb = 4'hF; i_wvalid = 1'b1;
    #1;
    chk("mrst1_cs_pre", o_sram_cs, 1);
    i_rst = 1'b1;
    #1;
    chk("mrst_awready", o_awready, 0);
    chk("mrst_wready", o_wready, 0);
    chk("mrst_bvalid", o_bvalid, 0);
    chk("mrst_bid", o_bid, 0);
    chk("mrst_bresp", o_bresp, 0);
    chk("mrst_cs", o_sram_cs, 0);
    chk("mrst_web", o_sram_web, 4'hF);
    chk("mrst_a", o_sram_a, 0);
    chk("mrst_di", o_sram_di, 0);
    i_wvalid = 1'b0;
    tick; tick;
    i_rst = 1'b0;
    tick;
    chk("mrst_awready_up", o_awready, 1);
    send_aw(8'h5A, 32'h0000_0800, 4'd0, 3'b010, 2'b01);
    send_beat("post", 32'h600D_F00D, 4'hF, 1'b1, 1'b1, 14'h0200);
    take_resp("post", 8'h5A, 2'b00);

    // Back-to-back single-beat bursts; W master raises wvalid one cycle after it sees wready
    aw0 = -1; aw1 = -1; n_aw = 0; w_pend = 1'b0;
    i_awid = 8'h99; i_awaddr = 32'h0000_0000; i_awlen = 4'd0; i_awsize = 3'b010; i_awburst = 2'b01;
    i_awvalid = 1'b1; i_bready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      i_wvalid = w_pend; i_wlast = 1'b1; i_wstrb = 4'hF; i_wdata = c;
      #1;
      if (i_awvalid && o_awready) begin
        if (n_aw == 0) aw0 = c; else aw1 = c;
        n_aw++;
      end
      if (i_wvalid && o_wready) w_pend = 1'b0;
      else if (o_wready) w_pend = 1'b1;
      tick;
      if (n_aw >= 2) i_awvalid = 1'b0;
    end
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
    chk("b2b_aw_count", n_aw, 2);
`ifdef AXI_WR_B2B_EN
    chk("b2b_aw_gap", aw1 - aw0, 3);
`else
    chk("b2b_aw_gap", aw1 - aw0, 4);
`endif
    #1;
    chk("b2b_end_bvalid", o_bvalid, 0);
    chk("b2b_end_awready", o_awready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
